// File: rtl/btn_debounce_pulse_if.sv
// Button conditioner bus: tick/raw/repeat-enable in,
// debounced level and one-cycle pulses out.
interface btn_debounce_pulse_if;
  logic tick;
  logic btn_raw;
  logic rpt_en;
  logic level;
  logic press;
  logic rel;
  logic step;

  modport master (
    output tick, btn_raw, rpt_en,
    input  level, press, rel, step
  );

  modport slave (
    input  tick, btn_raw, rpt_en,
    output level, press, rel, step
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button synchroniser, tick-based debouncer and
// press/release/auto-repeat step pulse generator.
module btn_debounce_pulse #(
  parameter int CNT_W        = 16,
  parameter int STABLE_TICKS = 4,
  parameter int RPT_DELAY    = 200,
  parameter int RPT_RATE     = 50
) (
  input  logic                 Clock,
  input  logic                 Reset,
  btn_debounce_pulse_if.slave  bus
);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LIM =
    CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] DLY_LIM =
    CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LIM =
    CNT_W'(RPT_RATE - 1);

  state_t           state;
  logic             s0;
  logic             s1;
  logic             level;
  logic             press;
  logic             rel;
  logic             step;
  logic             first;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rpt_cnt;

  logic             flip;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] rpt_lim;

  // level flips on this edge; FSM reacts on the same edge
  assign flip = bus.tick && (s1 != level) &&
                (deb_cnt == DEB_LIM);
  assign rise = flip && s1;
  assign fall = flip && !s1;
  assign rpt_lim = first ? DLY_LIM : RATE_LIM;

  assign bus.level = level;
  assign bus.press = press;
  assign bus.rel   = rel;
  assign bus.step  = step;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      step    <= 1'b0;
      first   <= 1'b1;
      deb_cnt <= '0;
      rpt_cnt <= '0;
      state   <= IDLE;
    end else begin
      s0    <= bus.btn_raw;
      s1    <= s0;
      press <= 1'b0;
      rel   <= 1'b0;
      step  <= 1'b0;

      if (bus.tick) begin
        if (s1 == level) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LIM) begin
          level   <= s1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (rise) begin
            state   <= HELD;
            press   <= 1'b1;
            step    <= 1'b1;
            rpt_cnt <= '0;
            first   <= 1'b1;
          end
        end
        HELD: begin
          // a due repeat is dropped on the release edge
          if (fall) begin
            state   <= IDLE;
            rel     <= 1'b1;
            rpt_cnt <= '0;
            first   <= 1'b1;
          end else if (!bus.rpt_en) begin
            rpt_cnt <= '0;
            first   <= 1'b1;
          end else if (bus.tick) begin
            if (rpt_cnt == rpt_lim) begin
              step    <= 1'b1;
              rpt_cnt <= '0;
              first   <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with an
// expected-pulse scoreboard keyed by clock edge number.
module tb_btn_debounce_pulse;

  typedef struct {
    int         cyc;
    logic [2:0] ev;
  } exp_t;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  int   cyc;
  exp_t q[$];

  btn_debounce_pulse_if bus ();

  btn_debounce_pulse #(
    .CNT_W        (16),
    .STABLE_TICKS (4),
    .RPT_DELAY    (10),
    .RPT_RATE     (3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ev bits: {press, rel, step}
  task automatic push(input int c, input logic [2:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    q.push_back(e);
  endtask

  task automatic cycle();
    logic [2:0] obs;
    exp_t       e;
    @(posedge Clock);
    cyc++;
    @(negedge Clock);
    obs = {bus.press, bus.rel, bus.step};
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL pulse edge=%0d got=%b want=%b",
                 cyc, obs, e.ev);
      end
    end else if (obs !== 3'b000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse edge=%0d got=%b want=000",
               cyc, obs);
    end
  endtask

  task automatic test_reset();
    int c0;
    Reset       = 1'b1;
    bus.btn_raw = 1'b1;
    bus.tick    = 1'b1;
    bus.rpt_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({bus.level, bus.press, bus.rel, bus.step} !== 4'b0) begin
        errors++;
        $display("FAIL reset_outputs got=%b want=0000",
                 {bus.level, bus.press, bus.rel, bus.step});
      end
    end
    Reset = 1'b0;
    c0 = cyc + 1;
    push(c0 + 5, 3'b101);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 4 || i == 5) begin
        checks++;
        if (bus.level !== (i == 5)) begin
          errors++;
          $display("FAIL reset_exit_level i=%0d got=%b want=%b",
                   i, bus.level, (i == 5));
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int c0;
    bus.btn_raw = 1'b0;
    c0 = cyc + 1;
    push(c0 + 5, 3'b010);
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (bus.level !== 1'b0) begin
      errors++;
      $display("FAIL clean_rel_level got=%b want=0", bus.level);
    end
    c0 = cyc + 1;
    push(c0 + 5, 3'b101);
    push(c0 + 25, 3'b010);
    for (int i = 0; i < 35; i++) begin
      bus.btn_raw = (i < 20);
      cycle();
      if (i == 24 || i == 25) begin
        checks++;
        if (bus.level !== (i == 24)) begin
          errors++;
          $display("FAIL clean_level i=%0d got=%b want=%b",
                   i, bus.level, (i == 24));
        end
      end
    end
  endtask

  task automatic test_bounce();
    int c0;
    c0 = cyc + 1;
    push(c0 + 25, 3'b101);
    push(c0 + 40, 3'b010);
    for (int i = 0; i < 50; i++) begin
      if (i < 20) bus.btn_raw = ((i / 2) % 2 == 0);
      else bus.btn_raw = (i < 35);
      cycle();
      if (i == 24) begin
        checks++;
        if (bus.level !== 1'b0) begin
          errors++;
          $display("FAIL bounce_level got=%b want=0", bus.level);
        end
      end
    end
  endtask

  task automatic test_slow_tick();
    int c0;
    c0 = cyc + 1;
    push(c0 + 15, 3'b101);
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.tick = (i % 4 == 3);
      cycle();
      if (i == 14 || i == 15) begin
        checks++;
        if (bus.level !== (i == 15)) begin
          errors++;
          $display("FAIL tick_level i=%0d got=%b want=%b",
                   i, bus.level, (i == 15));
        end
      end
    end
    bus.tick    = 1'b1;
    bus.btn_raw = 1'b0;
    c0 = cyc + 1;
    push(c0 + 5, 3'b010);
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_repeat();
    int c0;
    c0 = cyc + 1;
    push(c0 + 5, 3'b101);
    push(c0 + 15, 3'b001);
    push(c0 + 18, 3'b001);
    push(c0 + 21, 3'b001);
    push(c0 + 24, 3'b001);
    push(c0 + 44, 3'b001);
    push(c0 + 47, 3'b001);
    push(c0 + 50, 3'b001);
    push(c0 + 53, 3'b010);
    for (int i = 0; i < 60; i++) begin
      bus.btn_raw = (i < 48);
      bus.rpt_en  = !(i >= 25 && i < 35);
      cycle();
    end
  endtask

  task automatic test_reset_mid_hold();
    int c0;
    c0 = cyc + 1;
    push(c0 + 5, 3'b101);
    push(c0 + 15, 3'b001);
    push(c0 + 18, 3'b001);
    push(c0 + 27, 3'b101);
    push(c0 + 37, 3'b001);
    push(c0 + 40, 3'b001);
    push(c0 + 43, 3'b001);
    push(c0 + 46, 3'b010);
    bus.rpt_en = 1'b1;
    for (int i = 0; i < 52; i++) begin
      bus.btn_raw = (i < 41);
      Reset = (i == 20 || i == 21);
      cycle();
      if (i == 20 || i == 21) begin
        checks++;
        if ({bus.level, bus.press, bus.rel, bus.step} !== 4'b0) begin
          errors++;
          $display("FAIL mid_hold_reset i=%0d got=%b want=0000",
                   i, {bus.level, bus.press, bus.rel, bus.step});
        end
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    Reset       = 1'b1;
    bus.tick    = 1'b1;
    bus.btn_raw = 1'b0;
    bus.rpt_en  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_slow_tick();
    test_repeat();
    test_reset_mid_hold();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Upstream conditioning stage for the board push-buttons (step clock, reset) that feed the single-cycle CPU wrapper.
- Synchronises a raw asynchronous button and debounces it on a slow tick enable; the whole block runs on the single system clock.
- Emits a clean level, single-cycle press/release pulses, and an optional auto-repeat step pulse for holding the step button.

Parameters:
- CNT_W, 16, width of the debounce and repeat counters
- STABLE_TICKS, 4, consecutive ticks the synchronised input must differ from level before level flips (range 1..2^CNT_W-1)
- RPT_DELAY, 200, ticks held before the first auto-repeat step (range 1..2^CNT_W-1)
- RPT_RATE, 50, ticks between subsequent auto-repeat steps (range 1..2^CNT_W-1)

Ports:
- Clock, input, 1, system clock; all state changes on rising edge
- Reset, input, 1, synchronous, active-high
- tick, input, 1, one-Clock-wide enable (e.g. from divider); counters advance only when tick=1
- btn_raw, input, 1, asynchronous button, active-high
- rpt_en, input, 1, enables auto-repeat on step
- level, output, 1, debounced button state
- press, output, 1, one-Clock pulse on debounced 0->1
- release, output, 1, one-Clock pulse on debounced 1->0
- step, output, 1, one-Clock pulse on press and on each auto-repeat

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high.
- Reset, sampled at a rising edge, clears all state: s0, s1, level, press, release, step, deb_cnt, rpt_cnt and FSM=IDLE. Reset overrides tick and btn_raw, including mid-count or mid-hold.
- Synchroniser:
  - s0 <= btn_raw every Clock, independent of tick.
  - s1 <= s0 every Clock, independent of tick.
  - Only s1 is used downstream.
- Debounce, evaluated only on edges where tick=1:
  - If s1==level: deb_cnt <= 0.
  - Else if deb_cnt==STABLE_TICKS-1: level <= s1 and deb_cnt <= 0.
  - Else: deb_cnt <= deb_cnt+1.
  - Any tick with s1==level restarts the count, so glitches shorter than STABLE_TICKS ticks never change level.
  - Edges with tick=0 hold deb_cnt and level.
- Latency with tick=1 every cycle: btn_raw first sampled high at edge 0 gives level=1 after edge 1+STABLE_TICKS.
- Pulses: press, release and step are registered, high for exactly the one Clock following the edge that flips level or fires a repeat, then low.
- FSM, states IDLE / HELD:
  - IDLE: level=0. Entered on reset or whenever level falls.
  - IDLE -> HELD on the edge level rises: press=1, step=1, rpt_cnt<=0, first=1.
  - HELD -> IDLE on the edge level falls: release=1. No step is issued on that same edge, even if a repeat was due.
  - In HELD with rpt_en=1, on each tick, the limit is RPT_DELAY-1 while first=1, else RPT_RATE-1:
    - If rpt_cnt reaches the limit: step=1, rpt_cnt<=0, first<=0.
    - Otherwise rpt_cnt increments.
  - In HELD with rpt_en=0: rpt_cnt is held at 0 and first is held at 1. Re-enabling restarts the full RPT_DELAY.
- Counter widths: deb_cnt and rpt_cnt are CNT_W bits, unsigned. Parameter ranges guarantee they never wrap.
- Simultaneous events: press and release can never be high on the same cycle. step coincides with press only on the initial press.

Test Plan:
- Reset held for 3 cycles with btn_raw=1 -> all outputs 0 throughout. After release, with STABLE_TICKS=4 and tick=1 each cycle, level=1 at edge 5 after the first sample.
- Clean press (tick every cycle, STABLE_TICKS=4): btn_raw 0->1 sampled at edge 0 -> press=step=1 for exactly one cycle after edge 5. Release 20 cycles later -> release pulse 5 edges after the first low sample.
- Bounce: btn_raw toggles every 2 cycles for 20 cycles, then stays 1 -> no pulses during bouncing. A single press occurs 5 edges after btn_raw settles.
- tick every 4th cycle, STABLE_TICKS=4 -> level change occurs on the 4th qualifying tick (~16 cycles). No change occurs between ticks.
- Auto-repeat (RPT_DELAY=10, RPT_RATE=3, tick every cycle, rpt_en=1): hold button -> step at press, then 10 ticks later, then every 3 ticks. Dropping rpt_en mid-hold stops step; re-raising it waits 10 ticks again.
- Reset asserted mid-hold with repeats running -> level=0, all pulses 0, no release pulse. After reset is deasserted with the button still held -> new press after 1+STABLE_TICKS edges.
